// File: rtl/vector_tile_buffer.sv
// vector_tile_buffer: captures loader tiles into a slot-indexed buffer starting at base_tile,
// and serves whole tiles through a registered one-cycle read port.
module vector_tile_buffer #(
  parameter int TILE_WIDTH = 256,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TILES  = 32,
  localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH,
  localparam int IDX_W      = $clog2(NUM_TILES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_W-1:0]      base_tile,
  input  logic                  tile_valid,
  input  logic [DATA_WIDTH-1:0] tile_in [ELEM_COUNT],
  input  logic                  last_in,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_tile,
  output logic [DATA_WIDTH-1:0] rd_data [ELEM_COUNT],
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W:0]        tile_count,
  output logic                  overflow
);

  if (DATA_WIDTH != 8) begin : g_dw_chk
    $fatal(1, "vector_tile_buffer: DATA_WIDTH must be 8");
  end
  if (TILE_WIDTH % DATA_WIDTH != 0) begin : g_tw_chk
    $fatal(1, "vector_tile_buffer: TILE_WIDTH must be a multiple of DATA_WIDTH");
  end
  if (NUM_TILES < 2 || (NUM_TILES & (NUM_TILES - 1)) != 0) begin : g_nt_chk
    $fatal(1, "vector_tile_buffer: NUM_TILES must be a power of two >= 2");
  end

  localparam logic [IDX_W:0] CAP = (IDX_W + 1)'(NUM_TILES);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]        count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q [ELEM_COUNT];
  logic [DATA_WIDTH-1:0] rd_data_d [ELEM_COUNT];
  logic                  we;
  logic [DATA_WIDTH-1:0] mem [NUM_TILES][ELEM_COUNT];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    we         = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        wr_ptr_d   = base_tile;
        count_d    = '0;
        overflow_d = 1'b0;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        // a strobe coinciding with last_in is still written before finishing
        if (tile_valid) begin
          if (count_q < CAP) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (last_in) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_tile];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // storage is deliberately unreset so written slots survive a reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= tile_in;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign tile_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vector_tile_buffer.sv
// tb_vector_tile_buffer: directed vectors with hand-computed expectations for vector_tile_buffer.
module tb_vector_tile_buffer;
  localparam int EC = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          tile_valid = 1'b0;
  logic          last_in = 1'b0;
  logic          rd_en = 1'b0;
  logic [IW-1:0] base_tile = '0;
  logic [IW-1:0] rd_tile = '0;
  logic [7:0]    tile_in [EC];
  logic [7:0]    rd_data [EC];
  logic          rd_valid, busy, done, overflow;
  logic [IW:0]   tile_count;
  logic [255:0]  rd_flat;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  vector_tile_buffer #(.TILE_WIDTH(256), .DATA_WIDTH(8), .NUM_TILES(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_tile(base_tile),
    .tile_valid(tile_valid), .tile_in(tile_in), .last_in(last_in),
    .rd_en(rd_en), .rd_tile(rd_tile), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .tile_count(tile_count), .overflow(overflow)
  );

  always_comb for (int i = 0; i < EC; i++) rd_flat[i*8 +: 8] = rd_data[i];

  // tile k element i = k*32+i (+k/8 so tiles beyond 8 stay distinguishable)
  function automatic logic [255:0] pat(int k);
    logic [255:0] p;
    for (int i = 0; i < EC; i++) p[i*8 +: 8] = 8'(k * 32 + i + k / 8);
    return p;
  endfunction

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tile(int k);
    logic [255:0] p;
    p = pat(k);
    for (int i = 0; i < EC; i++) tile_in[i] = p[i*8 +: 8];
  endtask

  task automatic send(int k, bit last);
    tile_valid = 1'b1;
    set_tile(k);
    last_in = last;
    @(negedge clk);
    tile_valid = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic do_start(int b);
    start = 1'b1;
    base_tile = IW'(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rd(int slot, int k, string tag);
    rd_en = 1'b1;
    rd_tile = IW'(slot);
    @(negedge clk);
    rd_en = 1'b0;
    check({tag, "_v"}, rd_valid, 1);
    check(tag, rd_flat, pat(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_tile(0);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_cnt", tile_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rdd", rd_flat, 0);
    rst = 1'b1;
    @(negedge clk);

    do_start(0);
    check("t1_busy", busy, 1);
    for (int k = 0; k < 7; k++) send(k, 0);
    check("t1_nodone", done, 0);
    send(7, 1);
    check("t1_done", done, 1);
    check("t1_busy_done", busy, 1);
    check("t1_cnt", tile_count, 8);
    for (int s = 0; s < 8; s++) begin
      rd_en = 1'b1;
      rd_tile = IW'(s);
      @(negedge clk);
      if (s == 0) begin
        check("t1_done_gone", done, 0);
        check("t1_idle", busy, 0);
      end
      check("t1_rdv", rd_valid, 1);
      check($sformatf("t1_rd%0d", s), rd_flat, pat(s));
    end
    rd_en = 1'b0;
    @(negedge clk);
    check("t1_rdv_low", rd_valid, 0);
    check("t1_rd_hold", rd_flat, pat(7));

    do_start(30);
    for (int k = 100; k < 103; k++) send(k, 0);
    send(103, 1);
    check("t2_cnt", tile_count, 4);
    check("t2_ovf", overflow, 0);
    rd(30, 100, "t2_s30");
    rd(31, 101, "t2_s31");
    rd(0, 102, "t2_s0");
    rd(1, 103, "t2_s1");
    rd(2, 2, "t2_s2");

    do_start(0);
    for (int j = 0; j < 32; j++) send(200 + j, 0);
    check("t3_full_ovf", overflow, 0);
    send(232, 1);
    check("t3_cnt", tile_count, 32);
    check("t3_ovf", overflow, 1);
    rd(0, 200, "t3_s0");
    rd(31, 231, "t3_s31");
    check("t3_ovf_sticky", overflow, 1);
    do_start(0);
    check("t3_ovf_clr", overflow, 0);
    check("t3_cnt_clr", tile_count, 0);
    last_in = 1'b1;
    @(negedge clk);
    last_in = 1'b0;
    check("t3_last_done", done, 1);
    check("t3_last_cnt", tile_count, 0);

    @(negedge clk);
    do_start(0);
    send(60, 1);
    check("t4_done", done, 1);
    tile_valid = 1'b1;
    set_tile(61);
    start = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
    start = 1'b0;
    check("t4_idle", busy, 0);
    check("t4_cnt", tile_count, 1);
    tile_valid = 1'b1;
    set_tile(62);
    @(negedge clk);
    tile_valid = 1'b0;
    check("t4_idle_cnt", tile_count, 1);
    check("t4_idle_busy", busy, 0);
    rd(0, 60, "t4_s0");
    rd(1, 201, "t4_s1");

    do_start(5);
    tile_valid = 1'b1;
    set_tile(70);
    last_in = 1'b1;
    rd_en = 1'b1;
    rd_tile = IW'(5);
    @(negedge clk);
    tile_valid = 1'b0;
    last_in = 1'b0;
    rd_en = 1'b0;
    check("t5_old", rd_flat, pat(205));
    check("t5_done", done, 1);
    rd(5, 70, "t5_new");

    do_start(0);
    send(80, 0);
    rd_en = 1'b1;
    rd_tile = '0;
    send(81, 0);
    check("t6_pre_rdv", rd_valid, 1);
    tile_valid = 1'b1;
    set_tile(82);
    #2 rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_cnt", tile_count, 0);
    check("t6_rdv", rd_valid, 0);
    check("t6_rdd", rd_flat, 0);
    check("t6_done", done, 0);
    @(negedge clk);
    check("t6_done2", done, 0);
    check("t6_busy2", busy, 0);
    tile_valid = 1'b0;
    rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rd(0, 80, "t6_s0");
    rd(1, 81, "t6_s1");
    do_start(2);
    send(90, 0);
    send(91, 1);
    check("t6_new_done", done, 1);
    check("t6_new_cnt", tile_count, 2);
    rd(2, 90, "t6_s2");
    rd(3, 91, "t6_s3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_tile_buffer.md
# vector_tile_buffer

On-chip staging buffer that sits directly downstream of the vector DRAM loader. It captures each 256-bit tile the loader strobes out into a tile-indexed register array, starting at a caller-chosen tile slot. It then serves whole tiles to the compute datapath through a registered read port. It reports completion of a transfer with a one-cycle `done` pulse.

## Interface
- `TILE_WIDTH`, 256: bits per tile; must be a multiple of `DATA_WIDTH`.
- `DATA_WIDTH`, 8: bits per element; must be 8 (elaboration-time fatal otherwise).
- `NUM_TILES`, 32: buffer depth in tiles; must be a power of two ≥ 2.
- Derived: `ELEM_COUNT = TILE_WIDTH/DATA_WIDTH`; `IDX_W = $clog2(NUM_TILES)`.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a capture transfer; sampled only in IDLE.
- `base_tile`  in  IDX_W  first slot to write; latched on an accepted `start`.
- `tile_valid`  in  1  one-cycle strobe from the loader; `tile_in` is valid this cycle.
- `tile_in`  in  DATA_WIDTH × ELEM_COUNT (unpacked array)  tile elements.
- `last_in`  in  1  loader transfer-complete; may coincide with the final `tile_valid`.
- `rd_en`  in  1  read request.
- `rd_tile`  in  IDX_W  slot to read.
- `rd_data`  out  DATA_WIDTH × ELEM_COUNT  registered read data.
- `rd_valid`  out  1  `rd_data` is valid.
- `busy`  out  1  high in CAPTURE and DONE.
- `done`  out  1  one-cycle completion pulse.
- `tile_count`  out  IDX_W+1  tiles written in the current/last transfer.
- `overflow`  out  1  sticky: a tile was dropped because the buffer was full.

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - `start`=1 latches `wr_ptr<=base_tile`, clears `tile_count` and `overflow`, and moves to CAPTURE.
  - `tile_valid` and `last_in` are ignored.
- CAPTURE, on `tile_valid`=1:
  - If `tile_count < NUM_TILES`: write `mem[wr_ptr] <= tile_in`, `wr_ptr <= wr_ptr+1` (modulo NUM_TILES, wraps NUM_TILES-1→0), `tile_count++`.
  - Otherwise drop the tile and set `overflow<=1`.
- CAPTURE, on `last_in`=1: go to DONE.
  - If `tile_valid` is also high, that tile is written (or dropped) first, in the same cycle.
  - `last_in` without `tile_valid` moves to DONE with no write.
- CAPTURE: `start` is ignored.
- DONE: `done<=1` for exactly this one cycle, then return to IDLE. `start` is ignored in DONE.
- Read port is independent of state and operates in every state:
  - `rd_en`=1 → next cycle `rd_data<=mem[rd_tile]`, `rd_valid<=1`.
  - `rd_en`=0 → next cycle `rd_valid<=0`, `rd_data` holds its value.
- Read and write to the same slot in the same cycle: read returns the old contents (read-before-write).
- Tile storage is not reset; slot contents are undefined until written.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `wr_ptr`=0, `tile_count`=0, `overflow`=0, `done`=0, `rd_valid`=0, all `rd_data` elements=0. `busy`=0 as a decode of IDLE.
- Reset asserted mid-transfer: immediate abort to the reset values above, no `done` pulse. Already-written slots keep their contents.
- `start` at edge N → CAPTURE from N+1. `busy` is combinational from state: high from N+1.
- Write on `tile_valid` at edge M: `mem` is updated at M, so a read issued at M+1 or later sees the new data.
- `last_in` at edge L → DONE during L+1 (`done`=1, `busy`=1) → IDLE at L+2. `start` is accepted again from L+2.
- Read latency is exactly 1 cycle. Back-to-back reads give one result per cycle.
- `tile_count` saturates at NUM_TILES; `overflow` is stable from the drop cycle until the next accepted `start`.

## Test plan
- Reset, then `start` with base_tile=0, then 8 `tile_valid` strobes with tile k element i = k*32+i (mod 256), the 8th carrying `last_in` → `done` one cycle later, `tile_count`=8, reads of slots 0..7 return the pattern with `rd_valid` 1 cycle after `rd_en`.
- base_tile=30, 4 tiles → slots written in order 30, 31, 0, 1; `tile_count`=4; `overflow`=0.
- 33 tiles into NUM_TILES=32 → first 32 stored, 33rd dropped, `overflow`=1, `tile_count`=32. The next `start` clears `overflow` to 0.
- `tile_valid` and `start` asserted during DONE/IDLE outside a transfer → no writes, `tile_count` unchanged. `last_in` alone in CAPTURE → `done` with `tile_count` unchanged.
- Read of slot 5 in the same cycle as a write to slot 5 → old data returned; a read the next cycle → new data.
- `rst`=0 asserted during tile 3 of 8 → outputs at reset values asynchronously, no `done`. A new transfer after release completes normally.
